// File: rtl/eth_tx_gearbox_66_64_pkg.sv
// eth_tx_gearbox_66_64_pkg: shared constants and helpers for the 66b->64b TX gearbox
package eth_tx_gearbox_66_64_pkg;
   localparam int GBX_SEQ_W = 6;
   localparam logic [GBX_SEQ_W-1:0] GBX_SEQ_LAST = 6'd32;
   localparam int BLK_W = 66;
   localparam logic [1:0] IDLE_HDR = 2'b10;
   localparam logic [63:0] IDLE_DATA = 64'h0000_0000_0000_001E;
   function automatic logic [63:0] bit_rev64(input logic [63:0] x);
      for (int i = 0; i < 64; i++) bit_rev64[i] = x[63-i];
   endfunction
endpackage

// File: rtl/eth_tx_gearbox_66_64_if.sv
// eth_tx_gearbox_66_64_if: 66-bit block stream from the PHY TX path
// Signals: data (64b payload), hdr (2b sync header), valid (block present),
//   ready (gearbox takes the block this cycle, driven by the slave).
interface eth_tx_gearbox_66_64_if;
   logic [63:0] data;
   logic [1:0] hdr;
   logic valid;
   logic ready;
   modport master (output data, hdr, valid, input ready);
   modport slave (input data, hdr, valid, output ready);
endinterface

// File: rtl/eth_tx_gearbox_66_64.sv
// eth_tx_gearbox_66_64: packs 32 66-bit blocks into 33 continuous 64-bit words
// Ports: clk; rst_n (async assert, active low); s (slave block stream);
//   out_data (64b word, bit 0 first unless BIT_REVERSE); out_valid.
//   With ETH_TX_GEARBOX_UNDERRUN_CNT_EN defined: underrun_cnt (16b saturating
//   idle-substitution count) and underrun_flag (sticky), cleared only by rst_n.
module eth_tx_gearbox_66_64
   import eth_tx_gearbox_66_64_pkg::*;
#(
   parameter int DATA_WIDTH = 64,
   parameter int HDR_WIDTH = 2,
   parameter bit BIT_REVERSE = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   eth_tx_gearbox_66_64_if.slave s,
   output logic [63:0] out_data,
   output logic out_valid
`ifdef ETH_TX_GEARBOX_UNDERRUN_CNT_EN
   ,
   output logic [15:0] underrun_cnt,
   output logic underrun_flag
`endif
);
   logic [GBX_SEQ_W-1:0] seq;
   logic [63:0] residual;
   logic underrun;
   logic [BLK_W-1:0] blk;
   logic [127:0] merged;
   logic [63:0] word;
   if (DATA_WIDTH != 64 || HDR_WIDTH != 2) begin : g_bad_cfg
      $error("eth_tx_gearbox_66_64: only DATA_WIDTH=64 and HDR_WIDTH=2 are supported");
   end
   // residual holds 2*seq bits, so each new block lands right above them;
   // at seq 32 no block is taken and the 64 leftover bits drain as one word
   always_comb begin
      s.ready = rst_n && (seq != GBX_SEQ_LAST);
      underrun = s.ready && !s.valid;
      blk = !s.ready ? '0 : underrun ? {IDLE_DATA, IDLE_HDR} : {s.data, s.hdr};
      merged = {64'b0, residual} | ({62'b0, blk} << {seq, 1'b0});
      word = BIT_REVERSE ? bit_rev64(merged[63:0]) : merged[63:0];
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         seq <= '0;
         residual <= '0;
         out_data <= '0;
         out_valid <= 1'b0;
      end else begin
         seq <= (seq == GBX_SEQ_LAST) ? '0 : GBX_SEQ_W'(seq + 1);
         residual <= merged[127:64];
         out_data <= word;
         out_valid <= 1'b1;
      end
`ifdef ETH_TX_GEARBOX_UNDERRUN_CNT_EN
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         underrun_cnt <= '0;
         underrun_flag <= 1'b0;
      end else if (underrun) begin
         underrun_cnt <= (underrun_cnt == 16'hFFFF) ? underrun_cnt : underrun_cnt + 16'd1;
         underrun_flag <= 1'b1;
      end
`endif
endmodule

// File: tb/tb_eth_tx_gearbox_66_64.sv
// tb_eth_tx_gearbox_66_64: bit-serial scoreboard bench for the 66b->64b gearbox
module tb_eth_tx_gearbox_66_64;
   import eth_tx_gearbox_66_64_pkg::*;
   logic clk = 1'b0;
   logic rst_n = 1'b1;
   logic [63:0] out_data, rev_data;
   logic out_valid, rev_valid;
`ifdef ETH_TX_GEARBOX_UNDERRUN_CNT_EN
   logic [15:0] underrun_cnt, rev_cnt;
   logic underrun_flag, rev_flag;
`endif
   int n_chk = 0;
   int n_fail = 0;
   int m_seq = 0;
   int m_under = 0;
   logic [63:0] last_data = '0;
   bit bitq[$];
   logic [63:0] exp_q[$];
   eth_tx_gearbox_66_64_if tb_if ();
   eth_tx_gearbox_66_64_if rev_if ();
   always #5 clk = ~clk;
   eth_tx_gearbox_66_64 dut (
      .clk(clk), .rst_n(rst_n), .s(tb_if), .out_data(out_data), .out_valid(out_valid)
`ifdef ETH_TX_GEARBOX_UNDERRUN_CNT_EN
      , .underrun_cnt(underrun_cnt), .underrun_flag(underrun_flag)
`endif
   );
   eth_tx_gearbox_66_64 #(.BIT_REVERSE(1'b1)) dut_rev (
      .clk(clk), .rst_n(rst_n), .s(rev_if), .out_data(rev_data), .out_valid(rev_valid)
`ifdef ETH_TX_GEARBOX_UNDERRUN_CNT_EN
      , .underrun_cnt(rev_cnt), .underrun_flag(rev_flag)
`endif
   );
   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, act, exp);
      end
   endtask
   // the reference serialises every block bit by bit, low bit first
   task automatic push_block(input logic [65:0] b);
      logic [63:0] w;
      for (int i = 0; i < 66; i++) bitq.push_back(b[i]);
      while (bitq.size() >= 64) begin
         for (int i = 0; i < 64; i++) w[i] = bitq.pop_front();
         exp_q.push_back(w);
      end
   endtask
   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      check("rst_out_data", out_data, 64'h0);
      check("rst_out_valid", 64'(out_valid), 64'h0);
      check("rst_rev_data", rev_data, 64'h0);
      bitq.delete();
      exp_q.delete();
      m_seq = 0;
      m_under = 0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_in_ready", 64'(tb_if.ready), 64'h0);
      check("rst_hold_data", out_data, 64'h0);
      check("rst_hold_valid", 64'(rev_valid), 64'h0);
`ifdef ETH_TX_GEARBOX_UNDERRUN_CNT_EN
      check("rst_underrun_cnt", 64'(underrun_cnt), 64'h0);
      check("rst_underrun_flag", 64'(underrun_flag), 64'h0);
`endif
      rst_n = 1'b1;
   endtask
   task automatic cycle(input logic v, input logic [1:0] h, input logic [63:0] d);
      logic [65:0] b;
      bit was_last;
      tb_if.valid = v;
      tb_if.hdr = h;
      tb_if.data = d;
      #1;
      check("in_ready", 64'(tb_if.ready), 64'(m_seq != 32));
      was_last = (m_seq == 32);
      if (!was_last) begin
         b = v ? {d, h} : {IDLE_DATA, IDLE_HDR};
         if (!v) m_under++;
         last_data = b[65:2];
         push_block(b);
      end
      m_seq = was_last ? 0 : m_seq + 1;
      @(posedge clk);
      #1;
      check("out_valid", 64'(out_valid), 64'h1);
      if (exp_q.size() == 0) begin
         n_chk++;
         n_fail++;
         $display("FAIL out_data: got %h, expected word missing from scoreboard", out_data);
      end else check("out_data", out_data, exp_q.pop_front());
      if (was_last) check("seq32_word", out_data, last_data);
   endtask
   initial begin
      int drops;
      tb_if.valid = 1'b0;
      tb_if.hdr = 2'b00;
      tb_if.data = '0;
      rev_if.valid = 1'b1;
      rev_if.hdr = 2'b01;
      rev_if.data = '0;
      #2;
      do_reset();
      cycle(1'b1, 2'b01, 64'h0);
      check("rev_first_word", rev_data, 64'h8000_0000_0000_0000);
      for (int i = 0; i < 1000; i++)
         cycle(1'b1, 2'b01, m_seq == 32 ? 64'hDEAD_BEEF_0BAD_F00D : 64'(m_seq));
      drops = 0;
      while (drops < 3) begin
         if (m_seq != 32 && m_seq % 5 == 3) begin
            cycle(1'b0, 2'b01, 64'hFFFF_FFFF_FFFF_FFFF);
            drops++;
         end else cycle(1'b1, 2'b01, 64'(m_seq));
      end
      for (int i = 0; i < 40; i++) cycle(1'b1, 2'b01, 64'(m_seq));
`ifdef ETH_TX_GEARBOX_UNDERRUN_CNT_EN
      check("underrun_cnt", 64'(underrun_cnt), 64'(m_under));
      check("underrun_flag", 64'(underrun_flag), 64'(m_under != 0));
`endif
      while (m_seq != 17) cycle(1'b1, 2'b01, 64'(m_seq));
      do_reset();
      for (int i = 0; i < 80; i++)
         cycle($urandom_range(0, 7) != 0, 2'($urandom), {$urandom, $urandom});
`ifdef ETH_TX_GEARBOX_UNDERRUN_CNT_EN
      check("underrun_cnt_final", 64'(underrun_cnt), 64'(m_under));
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
